// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - RV32 5-stage pipeline control: decode, ID/EX/MEM/WB control stages, hazards, forwarding
module pipeline_ctrl #(
  parameter int REG_AW = 5,
  parameter int FWD_EN = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [6:0]        opcode_id,
  input  logic [REG_AW-1:0] rs1_id,
  input  logic [REG_AW-1:0] rs2_id,
  input  logic [REG_AW-1:0] rd_id,
  input  logic              branch_taken_ex,
  input  logic              mem_hold,
  output logic              stall,
  output logic              flush,
  output logic              alusrc_ex,
  output logic              branch_ex,
  output logic [1:0]        aluop_ex,
  output logic              illegal_ex,
  output logic [1:0]        forward_a,
  output logic [1:0]        forward_b,
  output logic              memread_mem,
  output logic              memwrite_mem,
  output logic              memtoreg_wb,
  output logic              regwrite_wb,
  output logic [REG_AW-1:0] rd_ex,
  output logic [REG_AW-1:0] rd_mem,
  output logic [REG_AW-1:0] rd_wb
);

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;

  logic       d_regwrite, d_memtoreg, d_memread, d_memwrite, d_alusrc, d_branch, d_illegal;
  logic [1:0] d_aluop;
  logic       use_rs1, use_rs2;

  logic              regwrite_ex, memtoreg_ex, memread_ex, memwrite_ex;
  logic [REG_AW-1:0] rs1_ex, rs2_ex;
  logic              regwrite_mem, memtoreg_mem;
  logic              hazard, taken, bubble;
  logic [1:0]        sel_a, sel_b;

  always_comb begin
    d_regwrite = 1'b0;
    d_memtoreg = 1'b0;
    d_memread  = 1'b0;
    d_memwrite = 1'b0;
    d_alusrc   = 1'b0;
    d_branch   = 1'b0;
    d_illegal  = 1'b0;
    d_aluop    = 2'b00;
    use_rs1    = 1'b1;
    use_rs2    = 1'b0;
    case (opcode_id)
      OP_R:  begin d_regwrite = 1'b1; d_aluop = 2'b10; use_rs2 = 1'b1; end
      OP_I:  begin d_alusrc = 1'b1; d_regwrite = 1'b1; d_aluop = 2'b11; end
      OP_LW: begin d_alusrc = 1'b1; d_memtoreg = 1'b1; d_regwrite = 1'b1; d_memread = 1'b1; end
      OP_SW: begin d_alusrc = 1'b1; d_memwrite = 1'b1; use_rs2 = 1'b1; end
      OP_BR: begin d_branch = 1'b1; d_aluop = 2'b01; use_rs2 = 1'b1; end
      default: begin d_illegal = 1'b1; use_rs1 = 1'b0; end
    endcase
  end

  assign hazard = memread_ex && (rd_ex != '0) &&
                  ((use_rs1 && (rs1_id == rd_ex)) || (use_rs2 && (rs2_id == rd_ex)));
  assign taken  = branch_ex & branch_taken_ex;
  assign bubble = taken | hazard;
  assign stall  = mem_hold | (hazard & ~taken);
  assign flush  = taken & ~mem_hold;

  // ID/EX stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regwrite_ex <= 1'b0; memtoreg_ex <= 1'b0; memread_ex <= 1'b0; memwrite_ex <= 1'b0;
      alusrc_ex   <= 1'b0; branch_ex   <= 1'b0; illegal_ex <= 1'b0; aluop_ex    <= 2'b00;
      rd_ex <= '0; rs1_ex <= '0; rs2_ex <= '0;
    end else if (!mem_hold) begin
      if (bubble) begin
        regwrite_ex <= 1'b0; memtoreg_ex <= 1'b0; memread_ex <= 1'b0; memwrite_ex <= 1'b0;
        alusrc_ex   <= 1'b0; branch_ex   <= 1'b0; illegal_ex <= 1'b0; aluop_ex    <= 2'b00;
        rd_ex <= '0; rs1_ex <= '0; rs2_ex <= '0;
      end else begin
        regwrite_ex <= d_regwrite; memtoreg_ex <= d_memtoreg;
        memread_ex  <= d_memread;  memwrite_ex <= d_memwrite;
        alusrc_ex   <= d_alusrc;   branch_ex   <= d_branch;
        illegal_ex  <= d_illegal;  aluop_ex    <= d_aluop;
        rd_ex <= rd_id; rs1_ex <= rs1_id; rs2_ex <= rs2_id;
      end
    end
  end

  // EX/MEM and MEM/WB stages
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regwrite_mem <= 1'b0; memtoreg_mem <= 1'b0; memread_mem <= 1'b0; memwrite_mem <= 1'b0;
      rd_mem <= '0;
      regwrite_wb <= 1'b0; memtoreg_wb <= 1'b0; rd_wb <= '0;
    end else if (!mem_hold) begin
      regwrite_mem <= regwrite_ex; memtoreg_mem <= memtoreg_ex;
      memread_mem  <= memread_ex;  memwrite_mem <= memwrite_ex;
      rd_mem       <= rd_ex;
      regwrite_wb  <= regwrite_mem; memtoreg_wb <= memtoreg_mem; rd_wb <= rd_mem;
    end
  end

  always_comb begin
    sel_a = 2'b00;
    sel_b = 2'b00;
    if (regwrite_mem && (rd_mem != '0) && (rd_mem == rs1_ex))     sel_a = 2'b10;
    else if (regwrite_wb && (rd_wb != '0) && (rd_wb == rs1_ex))   sel_a = 2'b01;
    if (regwrite_mem && (rd_mem != '0) && (rd_mem == rs2_ex))     sel_b = 2'b10;
    else if (regwrite_wb && (rd_wb != '0) && (rd_wb == rs2_ex))   sel_b = 2'b01;
  end

  assign forward_a = (FWD_EN != 0) ? sel_a : 2'b00;
  assign forward_b = (FWD_EN != 0) ? sel_b : 2'b00;

endmodule
